// File: rtl/inst_fetcher_pkg.sv
// Shared widths, defaults and FSM state encoding for the instruction fetch stage.
package inst_fetcher_pkg;
    localparam int unsigned ADDR_LEN         = 32;
    localparam int unsigned DATA_LEN         = 32;
    localparam int unsigned ICACHE_IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        MISS    = 2'd1,
        DRAIN   = 2'd2,
        WAIT_PC = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/inst_fetcher_if.sv
// Request/response bus between the instruction fetcher (master) and mem_ctrl (slave).
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic                out_mem_req;
    logic [ADDR_LEN-1:0] out_mem_addr;
    logic                in_mem_valid;
    logic [DATA_LEN-1:0] in_mem_inst;

    modport master (
        output out_mem_req,
        output out_mem_addr,
        input  in_mem_valid,
        input  in_mem_inst
    );

    modport slave (
        input  out_mem_req,
        input  out_mem_addr,
        output in_mem_valid,
        output in_mem_inst
    );
endinterface

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped I-cache, one word per line: combinational lookup, synchronous fill,
// valid bits cleared by the asynchronous active-low reset.
module inst_fetcher_icache_dm #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int unsigned LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays need no reset: a line is only observed through its valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rdata = data_q[rd_idx];
endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: looks up pc_reg's PC in the I-cache, fetches misses from
// mem_ctrl, and hands the word back to pc_reg and into the instruction queue.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  has_misbranch,
    input  logic [ADDR_LEN-1:0]   in_next_pc,
    input  logic                  in_pc_ready,
    output logic [DATA_LEN-1:0]   out_inst,
    output logic                  out_has_ask,
    input  logic                  in_iq_full,
    output logic                  out_iq_valid,
    output logic [DATA_LEN-1:0]   out_iq_inst,
    output logic [ADDR_LEN-1:0]   out_iq_pc,
    inst_fetcher_if.master        mem
);
    localparam int unsigned TAG_W = ADDR_LEN - ICACHE_IDX_W - 2;

    fetch_state_e        state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0] inst_q, inst_d;
    logic [ADDR_LEN-1:0] iq_pc_q, iq_pc_d;
    logic                has_ask_q, has_ask_d;
    logic                iq_valid_q, iq_valid_d;

    logic                cache_hit;
    logic [DATA_LEN-1:0] cache_rdata;
    logic                fill_we;
    logic                unused_addr_bits;

    inst_fetcher_icache_dm #(
        .IDX_W  (ICACHE_IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_LEN)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (in_next_pc[ICACHE_IDX_W+1:2]),
        .rd_tag  (in_next_pc[ADDR_LEN-1:ICACHE_IDX_W+2]),
        .hit     (cache_hit),
        .rdata   (cache_rdata),
        .we      (fill_we),
        .wr_idx  (mem_addr_q[ICACHE_IDX_W+1:2]),
        .wr_tag  (mem_addr_q[ADDR_LEN-1:ICACHE_IDX_W+2]),
        .wr_data (mem.in_mem_inst)
    );

    assign unused_addr_bits = ^{in_next_pc[1:0], mem_addr_q[1:0]};

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_d     = inst_q;
        iq_pc_d    = iq_pc_q;
        has_ask_d  = has_ask_q;
        iq_valid_d = iq_valid_q;
        fill_we    = 1'b0;

        if (has_misbranch) begin
            has_ask_d  = 1'b0;
            iq_valid_d = 1'b0;
            // An outstanding request must still be retired; a response arriving on the
            // flush edge itself completes the drain immediately.
            unique case (state_q)
                MISS, DRAIN: begin
                    if (mem.in_mem_valid) begin
                        fill_we   = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else if (rdy) begin
            has_ask_d  = 1'b0;
            iq_valid_d = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (!in_iq_full) begin
                        if (cache_hit) begin
                            inst_d     = cache_rdata;
                            iq_pc_d    = in_next_pc;
                            has_ask_d  = 1'b1;
                            iq_valid_d = 1'b1;
                            state_d    = WAIT_PC;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = in_next_pc;
                            state_d    = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem.in_mem_valid) begin
                        fill_we    = 1'b1;
                        mem_req_d  = 1'b0;
                        inst_d     = mem.in_mem_inst;
                        iq_pc_d    = mem_addr_q;
                        has_ask_d  = 1'b1;
                        iq_valid_d = 1'b1;
                        state_d    = WAIT_PC;
                    end
                end
                DRAIN: begin
                    if (mem.in_mem_valid) begin
                        fill_we   = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
                WAIT_PC: begin
                    if (in_pc_ready) begin
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inst_q     <= '0;
            iq_pc_q    <= '0;
            has_ask_q  <= 1'b0;
            iq_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_q     <= inst_d;
            iq_pc_q    <= iq_pc_d;
            has_ask_q  <= has_ask_d;
            iq_valid_q <= iq_valid_d;
        end
    end

    assign out_inst         = inst_q;
    assign out_iq_inst      = inst_q;
    assign out_iq_pc        = iq_pc_q;
    assign out_has_ask      = has_ask_q;
    assign out_iq_valid     = iq_valid_q;
    assign mem.out_mem_req  = mem_req_q;
    assign mem.out_mem_addr = mem_addr_q;
endmodule
